// File: rtl/jtgng_sdram_pkg.sv
// Shared definitions for the jtgng SDRAM controller: command pin encodings,
// controller state names and the mode-register word.
package jtgng_sdram_pkg;

    // {nCS, nRAS, nCAS, nWE}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    typedef enum logic [4:0] {
        INIT_WAIT,
        INIT_PRE,
        INIT_REF1,
        INIT_REF2,
        INIT_MRS,
        IDLE,
        ACT,
        RD_WAIT,
        READ,
        CAS_WAIT,
        LATCH,
        PRE_WAIT,
        REF,
        WR_ACT,
        WR_WAIT,
        WRITE,
        WR_NOP
    } state_t;

    // Burst length 1, sequential, CAS latency in A[6:4]
    function automatic logic [12:0] mode_word(input int cl);
        return {3'b000, 1'b0, 2'b00, 3'(cl), 1'b0, 3'b000};
    endfunction

endpackage

// File: rtl/jtgng_sdram_init.sv
// Power-up sequencer: waits INIT_CYCLES, then PRECHARGE ALL, two AUTO REFRESH
// and MODE REGISTER SET. The command shown is the one the top registers this clock.
module jtgng_sdram_init
    import jtgng_sdram_pkg::*;
#(
    parameter int INIT_CYCLES = 19200,
    parameter int TRC         = 7,
    parameter int CL          = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        done,
    output logic [3:0]  cmd,
    output logic [12:0] addr
);

    state_t      st;
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= INIT_WAIT;
            cnt <= 16'(INIT_CYCLES - 1);
        end else begin
            case (st)
                INIT_WAIT: begin
                    if (cnt == 16'd0) st <= INIT_PRE;
                    else              cnt <= cnt - 16'd1;
                end
                INIT_PRE: begin
                    st  <= INIT_REF1;
                    cnt <= 16'd0;
                end
                INIT_REF1, INIT_REF2: begin
                    if (cnt == 16'(TRC - 1)) begin
                        st  <= (st == INIT_REF1) ? INIT_REF2 : INIT_MRS;
                        cnt <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                // One extra NOP after MRS so loop_rst drops two clocks after it
                INIT_MRS: begin
                    if (cnt == 16'd1) st <= IDLE;
                    else              cnt <= cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd  = CMD_NOP;
        addr = 13'd0;
        done = (st == IDLE);
        case (st)
            INIT_PRE: begin
                cmd  = CMD_PRE;
                addr = 13'h0400;
            end
            INIT_REF1, INIT_REF2: begin
                if (cnt == 16'd0) cmd = CMD_REF;
            end
            INIT_MRS: begin
                if (cnt == 16'd0) begin
                    cmd  = CMD_MRS;
                    addr = mode_word(CL);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/jtgng_sdram.sv
// SDRAM command controller for the ROM slot scheduler: toggle-request reads or
// refreshes, ROM download writes, and the power-up sequence behind loop_rst.
module jtgng_sdram
    import jtgng_sdram_pkg::*;
#(
    parameter int INIT_CYCLES = 19200,
    parameter int TRCD        = 2,
    parameter int CL          = 2,
    parameter int TRC         = 7
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic        loop_rst,
    input  logic        sdram_re,
    input  logic [21:0] sdram_addr,
    input  logic        autorefresh,
    output logic [15:0] data_read,
    input  logic        downloading,
    input  logic [21:0] romload_addr,
    input  logic [15:0] romload_data,
    input  logic        romload_wr,
    inout  wire  [15:0] SDRAM_DQ,
    output logic [12:0] SDRAM_A,
    output logic [1:0]  SDRAM_BA,
    output logic        SDRAM_nCS,
    output logic        SDRAM_nRAS,
    output logic        SDRAM_nCAS,
    output logic        SDRAM_nWE,
    output logic        SDRAM_DQML,
    output logic        SDRAM_DQMH,
    output logic        SDRAM_CKE
);

    state_t      state;
    logic [3:0]  cmd;
    logic [12:0] a;
    logic [1:0]  dqm;
    logic [15:0] cnt;
    logic [8:0]  col;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        served;
    logic        wr_pend;
    logic [21:0] wr_addr;
    logic [15:0] wr_data;
    logic        init_done;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        req_pend;

    jtgng_sdram_init #(
        .INIT_CYCLES (INIT_CYCLES),
        .TRC         (TRC),
        .CL          (CL)
    ) u_init (
        .clk   (clk),
        .rst_n (rst_n),
        .done  (init_done),
        .cmd   (init_cmd),
        .addr  (init_addr)
    );

    assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd;
    assign SDRAM_A                  = a;
    assign SDRAM_BA                 = 2'b00;
    assign SDRAM_CKE                = 1'b1;
    assign {SDRAM_DQMH, SDRAM_DQML} = dqm;
    assign SDRAM_DQ                 = dq_oe ? dq_out : 16'hzzzz;

    // A toggle that differs from the last one served is an outstanding request
    assign req_pend = (sdram_re != served);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT_WAIT;
            cmd       <= CMD_NOP;
            a         <= 13'd0;
            dqm       <= 2'b11;
            cnt       <= 16'd0;
            col       <= 9'd0;
            dq_out    <= 16'd0;
            dq_oe     <= 1'b0;
            served    <= 1'b0;
            wr_pend   <= 1'b0;
            wr_addr   <= 22'd0;
            wr_data   <= 16'd0;
            data_read <= 16'd0;
            loop_rst  <= 1'b1;
        end else begin
            case (state)
                INIT_WAIT: begin
                    cmd <= init_cmd;
                    a   <= init_addr;
                    if (init_done) begin
                        state    <= IDLE;
                        loop_rst <= 1'b0;
                    end
                end
                IDLE: begin
                    cmd <= CMD_NOP;
                    if (wr_pend && downloading) begin
                        cmd     <= CMD_ACT;
                        a       <= wr_addr[21:9];
                        col     <= wr_addr[8:0];
                        dq_out  <= wr_data;
                        wr_pend <= 1'b0;
                        state   <= WR_ACT;
                    end else if (req_pend) begin
                        served <= sdram_re;
                        if (autorefresh) begin
                            cmd   <= CMD_REF;
                            cnt   <= 16'(TRC - 2);
                            state <= REF;
                        end else begin
                            cmd   <= CMD_ACT;
                            a     <= sdram_addr[21:9];
                            col   <= sdram_addr[8:0];
                            state <= ACT;
                        end
                    end
                end
                ACT: begin
                    cmd   <= CMD_NOP;
                    cnt   <= 16'(TRCD - 2);
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt == 16'd0) begin
                        cmd   <= CMD_READ;
                        a     <= {2'b00, 1'b1, 1'b0, col};
                        dqm   <= 2'b00;
                        state <= READ;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                READ: begin
                    cmd   <= CMD_NOP;
                    dqm   <= 2'b11;
                    cnt   <= 16'(CL - 2);
                    state <= CAS_WAIT;
                end
                CAS_WAIT: begin
                    if (cnt == 16'd0) begin
                        data_read <= SDRAM_DQ;
                        state     <= LATCH;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                LATCH:    state <= PRE_WAIT;
                PRE_WAIT: state <= IDLE;
                REF: begin
                    cmd <= CMD_NOP;
                    if (cnt == 16'd0) state <= IDLE;
                    else              cnt <= cnt - 16'd1;
                end
                WR_ACT: begin
                    cmd   <= CMD_NOP;
                    cnt   <= 16'(TRCD - 2);
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (cnt == 16'd0) begin
                        cmd   <= CMD_WRITE;
                        a     <= {2'b00, 1'b1, 1'b0, col};
                        dqm   <= 2'b00;
                        dq_oe <= 1'b1;
                        state <= WRITE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                WRITE: begin
                    cmd   <= CMD_NOP;
                    dqm   <= 2'b11;
                    dq_oe <= 1'b0;
                    cnt   <= 16'd1;
                    state <= WR_NOP;
                end
                WR_NOP: begin
                    if (cnt == 16'd0) state <= IDLE;
                    else              cnt <= cnt - 16'd1;
                end
                default: begin
                    cmd   <= CMD_NOP;
                    state <= IDLE;
                end
            endcase

            // A fresh strobe wins over the clear of a write starting this clock
            if (romload_wr) begin
                wr_pend <= 1'b1;
                wr_addr <= romload_addr;
                wr_data <= romload_data;
            end
        end
    end

endmodule
